// File: rtl/ship_board_ctrl.sv
// ship_board_ctrl
//
// Holds the host and guest 8x8 ship boards (2-bit cell codes: 00 water,
// 01 miss, 10 ship, 11 hit) and serves one host cell and one guest cell per
// clock to the ship renderer. Writes come from the local game FSM (port A)
// and the remote UART link (port B) through a one-write-per-cycle arbiter.
// A clear sequence sweeps all cells back to water. Per-board counters track
// the number of intact ship cells so the game can detect a sunk fleet.
//
// Build option:
//   SHIP_BOARD_RR_EN  defined   -> round-robin arbitration between A and B
//                     undefined -> fixed priority, A wins when both are valid
//
// Ports:
//   clk, rst                       pixel clock, synchronous active-high reset
//   rd_addr_host/guest  [5:0]  in  renderer cell index (row*8+col)
//   rd_data_host/guest  [1:0]  out cell code, registered (1-cycle latency)
//   a_/b_valid, a_/b_addr[6:0], a_/b_data[1:0]  in   write requests;
//                                  addr bit 6 selects board (0 host, 1 guest)
//   a_/b_ready                 out grant (combinational)
//   clr_start                  in  single-cycle pulse starting a board clear
//   busy                       out high while the clear sweep runs
//   host_left/guest_left [6:0] out ship cells (code 10) remaining, 0..64
//   host_dead/guest_dead       out board armed and no ship cells left
//   state_dbg                  out FSM state (0 idle, 1 clearing)
//
// Handshake: a requester's write commits at the clock edge where both its
// valid and ready are high. Ready never rises without the matching valid, is
// held low for both requesters while clearing, and at most one requester is
// granted per cycle. Requesters may change valid freely; there is no
// obligation to hold a request that has not been granted.

module ship_board_ctrl #(
  parameter int CLR_CELLS = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] rd_addr_host,
  input  logic [5:0] rd_addr_guest,
  output logic [1:0] rd_data_host,
  output logic [1:0] rd_data_guest,
  input  logic       a_valid,
  input  logic [6:0] a_addr,
  input  logic [1:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [6:0] b_addr,
  input  logic [1:0] b_data,
  output logic       b_ready,
  input  logic       clr_start,
  output logic       busy,
  output logic [6:0] host_left,
  output logic [6:0] guest_left,
  output logic       host_dead,
  output logic       guest_dead,
  output logic       state_dbg
);

  localparam int PW = $clog2(CLR_CELLS);
  localparam logic [1:0] CODE_SHIP = 2'b10;
  localparam logic [6:0] MAX_LEFT  = 7'd64;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          state;
  logic [PW-1:0]   clr_ptr;
  logic [1:0]      mem [0:127];
  logic            host_armed;
  logic            guest_armed;

`ifdef SHIP_BOARD_RR_EN
  // 0: A preferred, 1: B preferred
  logic            rr_ptr_b;
`endif

  logic            idle;
  logic            wr_en;
  logic [6:0]      wr_addr;
  logic [1:0]      wr_data;
  logic [1:0]      old_code;
  logic [6:0]      host_left_nxt;
  logic [6:0]      guest_left_nxt;
  logic            host_armed_nxt;
  logic            guest_armed_nxt;

  // Ship-cell bookkeeping: a write that creates a ship cell adds one, a
  // write that destroys one removes one, clamped to the board size.
  function automatic logic [6:0] count_next(input logic [6:0] cnt,
                                            input logic [1:0] old_c,
                                            input logic [1:0] new_c);
    logic [6:0] r;
    r = cnt;
    if (old_c != CODE_SHIP && new_c == CODE_SHIP && cnt != MAX_LEFT)
      r = cnt + 7'd1;
    else if (old_c == CODE_SHIP && new_c != CODE_SHIP && cnt != 7'd0)
      r = cnt - 7'd1;
    return r;
  endfunction

  always_comb begin
    idle = (state == S_IDLE);
`ifdef SHIP_BOARD_RR_EN
    a_ready = idle & a_valid & (~b_valid | ~rr_ptr_b);
    b_ready = idle & b_valid & (~a_valid |  rr_ptr_b);
`else
    a_ready = idle & a_valid;
    b_ready = idle & b_valid & ~a_valid;
`endif
    wr_en   = a_ready | b_ready;
    wr_addr = a_ready ? a_addr : b_addr;
    wr_data = a_ready ? a_data : b_data;
    old_code = mem[wr_addr];

    host_left_nxt   = host_left;
    guest_left_nxt  = guest_left;
    host_armed_nxt  = host_armed;
    guest_armed_nxt = guest_armed;
    if (wr_en) begin
      if (wr_addr[6]) begin
        guest_left_nxt  = count_next(guest_left, old_code, wr_data);
        guest_armed_nxt = guest_armed | (wr_data == CODE_SHIP);
      end else begin
        host_left_nxt   = count_next(host_left, old_code, wr_data);
        host_armed_nxt  = host_armed | (wr_data == CODE_SHIP);
      end
    end
  end

  // Cell storage and the two registered read ports. The clear sweep and the
  // arbitrated write never coincide because both readies are low in CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 2'b00;
      rd_data_host  <= 2'b00;
      rd_data_guest <= 2'b00;
    end else begin
      if (state == S_CLEAR)
        mem[7'(clr_ptr)] <= 2'b00;
      else if (wr_en)
        mem[wr_addr] <= wr_data;
      rd_data_host  <= mem[{1'b0, rd_addr_host}];
      rd_data_guest <= mem[{1'b1, rd_addr_guest}];
    end
  end

  // Control FSM with counters, arming flags and dead flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      clr_ptr     <= '0;
      busy        <= 1'b0;
      host_left   <= 7'd0;
      guest_left  <= 7'd0;
      host_armed  <= 1'b0;
      guest_armed <= 1'b0;
      host_dead   <= 1'b0;
      guest_dead  <= 1'b0;
`ifdef SHIP_BOARD_RR_EN
      rr_ptr_b    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          host_left   <= host_left_nxt;
          guest_left  <= guest_left_nxt;
          host_armed  <= host_armed_nxt;
          guest_armed <= guest_armed_nxt;
          host_dead   <= host_armed_nxt  & (host_left_nxt  == 7'd0);
          guest_dead  <= guest_armed_nxt & (guest_left_nxt == 7'd0);
`ifdef SHIP_BOARD_RR_EN
          if (a_ready)
            rr_ptr_b <= 1'b1;
          else if (b_ready)
            rr_ptr_b <= 1'b0;
`endif
          // A write granted alongside clr_start still commits above.
          if (clr_start) begin
            state   <= S_CLEAR;
            busy    <= 1'b1;
            clr_ptr <= '0;
          end
        end
        S_CLEAR: begin
          // No writes are granted here, so zeroing every cycle is the same
          // as zeroing on the first sweep cycle.
          host_left   <= 7'd0;
          guest_left  <= 7'd0;
          host_armed  <= 1'b0;
          guest_armed <= 1'b0;
          host_dead   <= 1'b0;
          guest_dead  <= 1'b0;
          clr_ptr     <= clr_ptr + PW'(1);
          if (clr_ptr == PW'(CLR_CELLS - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ship_board_ctrl.sv
// Directed bench for ship_board_ctrl: reset state, ship counting and dead
// detection, read latency, arbitration, clear sweep and reset mid-clear.
// Inputs are driven and outputs sampled 1 ns after the rising edge.

module tb_ship_board_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] rd_addr_host;
  logic [5:0] rd_addr_guest;
  logic [1:0] rd_data_host;
  logic [1:0] rd_data_guest;
  logic       a_valid;
  logic [6:0] a_addr;
  logic [1:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [6:0] b_addr;
  logic [1:0] b_data;
  logic       b_ready;
  logic       clr_start;
  logic       busy;
  logic [6:0] host_left;
  logic [6:0] guest_left;
  logic       host_dead;
  logic       guest_dead;
  logic       state_dbg;

  int checks;
  int failures;

  ship_board_ctrl #(.CLR_CELLS(128)) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_addr_host  (rd_addr_host),
    .rd_addr_guest (rd_addr_guest),
    .rd_data_host  (rd_data_host),
    .rd_data_guest (rd_data_guest),
    .a_valid       (a_valid),
    .a_addr        (a_addr),
    .a_data        (a_data),
    .a_ready       (a_ready),
    .b_valid       (b_valid),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .b_ready       (b_ready),
    .clr_start     (clr_start),
    .busy          (busy),
    .host_left     (host_left),
    .guest_left    (guest_left),
    .host_dead     (host_dead),
    .guest_dead    (guest_dead),
    .state_dbg     (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks: one request, held for exactly one edge, grant checked first
  task automatic write_a(input logic [6:0] addr, input logic [1:0] data);
    a_valid = 1'b1;
    a_addr  = addr;
    a_data  = data;
    #1;
    chk1("write_a_ready", a_ready, 1'b1);
    step();
    a_valid = 1'b0;
  endtask

  task automatic write_b(input logic [6:0] addr, input logic [1:0] data);
    b_valid = 1'b1;
    b_addr  = addr;
    b_data  = data;
    #1;
    chk1("write_b_ready", b_ready, 1'b1);
    step();
    b_valid = 1'b0;
  endtask

  initial begin
    logic exp_a;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    rd_addr_host = 6'd0;
    rd_addr_guest = 6'd0;
    a_valid = 1'b0; a_addr = 7'd0; a_data = 2'b00;
    b_valid = 1'b0; b_addr = 7'd0; b_data = 2'b00;
    clr_start = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk1("rst_busy", busy, 1'b0);
    chk7("rst_host_left", host_left, 7'd0);
    chk7("rst_guest_left", guest_left, 7'd0);
    chk1("rst_host_dead", host_dead, 1'b0);
    chk1("rst_guest_dead", guest_dead, 1'b0);
    chk1("rst_state", state_dbg, 1'b0);
    chk1("rst_a_ready_idle", a_ready, 1'b0);
    chk1("rst_b_ready_idle", b_ready, 1'b0);
    rd_addr_host = 6'd0; rd_addr_guest = 6'd0;
    step();
    chk2("rst_rd_host0", rd_data_host, 2'b00);
    chk2("rst_rd_guest0", rd_data_guest, 2'b00);
    rd_addr_host = 6'd63; rd_addr_guest = 6'd63;
    step();
    chk2("rst_rd_host63", rd_data_host, 2'b00);
    chk2("rst_rd_guest63", rd_data_guest, 2'b00);

    // host cell 9: ship, ship again, then hit
    write_a(7'd9, 2'b10);
    chk7("ship1_host_left", host_left, 7'd1);
    chk1("ship1_host_dead", host_dead, 1'b0);
    write_a(7'd9, 2'b10);
    chk7("ship2_host_left", host_left, 7'd1);
    chk1("ship2_host_dead", host_dead, 1'b0);
    write_a(7'd9, 2'b11);
    chk7("hit_host_left", host_left, 7'd0);
    chk1("hit_host_dead", host_dead, 1'b1);
    rd_addr_host = 6'd9;
    step();
    chk2("rd_host9", rd_data_host, 2'b11);

    // no same-edge bypass: read and write of cell 12 at the same edge
    rd_addr_host = 6'd12;
    a_valid = 1'b1; a_addr = 7'd12; a_data = 2'b01;
    step();
    a_valid = 1'b0;
    chk2("nobypass_old", rd_data_host, 2'b00);
    step();
    chk2("nobypass_new", rd_data_host, 2'b01);

    // arbitration from a fresh reset (pointer at A)
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rst2_host_dead", host_dead, 1'b0);
    chk7("rst2_host_left", host_left, 7'd0);
    a_valid = 1'b1; a_addr = 7'd10; a_data = 2'b01;
    b_valid = 1'b1; b_addr = 7'd11; b_data = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef SHIP_BOARD_RR_EN
      exp_a = ((i % 2) == 0);
`else
      exp_a = 1'b1;
`endif
      chk1("arb_a_ready", a_ready, exp_a);
      chk1("arb_b_ready", b_ready, ~exp_a);
      step();
    end
    a_valid = 1'b0;
    #1;
    chk1("arb_lone_b_ready", b_ready, 1'b1);
    chk1("arb_lone_a_ready", a_ready, 1'b0);
    step();
    b_valid = 1'b0;

    // guest board counting, host counter unaffected
    write_a(7'd20, 2'b10);
    chk7("host20_host_left", host_left, 7'd1);
    for (int k = 0; k < 4; k++) begin
      write_a(7'(64 + k), 2'b10);
      chk7("guest_left_inc", guest_left, 7'(k + 1));
      chk7("guest_host_left_same", host_left, 7'd1);
    end
    write_b(7'd100, 2'b10);
    chk7("guest_b_left5", guest_left, 7'd5);
    chk1("guest_dead_armed_nz", guest_dead, 1'b0);
    write_b(7'd100, 2'b01);
    chk7("guest_b_left_dec", guest_left, 7'd4);
    write_b(7'd100, 2'b10);
    chk7("guest_b_left_back", guest_left, 7'd5);

    // clear, started together with a granted write
    a_valid = 1'b1; a_addr = 7'd21; a_data = 2'b10;
    clr_start = 1'b1;
    #1;
    chk1("clr_same_cycle_a_ready", a_ready, 1'b1);
    step();
    a_valid = 1'b0;
    clr_start = 1'b0;
    chk7("clr_same_cycle_host_left", host_left, 7'd2);
    chk1("clr_state", state_dbg, 1'b1);
    a_valid = 1'b1; a_addr = 7'd30; a_data = 2'b10;
    b_valid = 1'b1; b_addr = 7'd31; b_data = 2'b10;
    for (int i = 0; i < 128; i++) begin
      chk1("clr_busy", busy, 1'b1);
      chk1("clr_a_ready", a_ready, 1'b0);
      chk1("clr_b_ready", b_ready, 1'b0);
      step();
      if (i == 0) begin
        chk7("clr_guest_left0", guest_left, 7'd0);
        chk7("clr_host_left0", host_left, 7'd0);
        chk1("clr_guest_dead", guest_dead, 1'b0);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk1("clr_done_busy", busy, 1'b0);
    chk1("clr_done_state", state_dbg, 1'b0);
    chk1("clr_done_guest_dead", guest_dead, 1'b0);
    for (int i = 0; i < 64; i++) begin
      rd_addr_host = 6'(i);
      rd_addr_guest = 6'(i);
      step();
      chk2("clr_rd_host", rd_data_host, 2'b00);
      chk2("clr_rd_guest", rd_data_guest, 2'b00);
    end
    // armed flag was dropped by the clear
    write_a(7'd5, 2'b01);
    chk7("unarmed_host_left", host_left, 7'd0);
    chk1("unarmed_host_dead", host_dead, 1'b0);

    // reset in the middle of a clear
    write_a(7'd50, 2'b10);
    chk7("pre_abort_host_left", host_left, 7'd1);
    write_a(7'd67, 2'b11);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    chk1("abort_busy_start", busy, 1'b1);
    repeat (40) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_state", state_dbg, 1'b0);
    chk7("abort_host_left", host_left, 7'd0);
    write_a(7'd40, 2'b10);
    chk7("abort_write_host_left", host_left, 7'd1);
    rd_addr_host = 6'd50; rd_addr_guest = 6'd3;
    step();
    chk2("abort_rd_host50", rd_data_host, 2'b00);
    chk2("abort_rd_guest3", rd_data_guest, 2'b00);
    rd_addr_host = 6'd40;
    step();
    chk2("abort_rd_host40", rd_data_host, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
